ip4_rtl_rdbuf: RTL and testbench

//  Read-response buffer downstream of the core's AXI master read channel.

---
 rtl/ip4_rtl_pkg.sv | 22 ++
 rtl/ip4_rtl_rdbuf_fifo.sv | 50 +++++
 rtl/ip4_rtl_rdbuf.sv | 155 +++++++++++++++
 tb/tb_ip4_rtl_rdbuf.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ip4_rtl_pkg.sv
// Shared types for the read-response buffer: AR FSM states and the stored R beat layout.
package ip4_rtl_pkg;

    localparam int unsigned RB_DATA_W = 128;
    localparam int unsigned RB_ID_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        ISSUE
    } rdbuf_st_e;

    typedef struct packed {
        logic [RB_DATA_W-1:0] data;
        logic [RB_ID_W-1:0]   id;
        logic [1:0]           resp;
        logic                 last;
    } r_beat_s;

    localparam int unsigned RB_W = $bits(r_beat_s);

endpackage

// File: rtl/ip4_rtl_rdbuf_fifo.sv
// Synchronous beat FIFO; the head entry is presented directly from the storage flops.
module ip4_rtl_rdbuf_fifo
    import ip4_rtl_pkg::*;
#(
    parameter int unsigned DEPTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr,
    input  logic [RB_W-1:0] wdata,
    input  logic            rd,
    output logic [RB_W-1:0] rdata,
    output logic            empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [RB_W-1:0] mem [DEPTH];
    logic [AW:0]     wptr;
    logic [AW:0]     rptr;
    logic            full;
    logic            do_rd;

    // Extra pointer bit separates full from empty when the indices match
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_rd = rd && !empty;
    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr) begin
                mem[wptr[AW-1:0]] <= wdata;
                wptr              <= wptr + (AW+1)'(1);
            end
            if (do_rd) begin
                rptr <= rptr + (AW+1)'(1);
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(wr && full && !rd));

endmodule

// File: rtl/ip4_rtl_rdbuf.sv
// AXI read-response buffer: reserves FIFO space per AR burst before issue and caps outstanding reads.
// Define IP4_RDBUF_ERR_EN to add sticky err_flag and saturating err_cnt for SLVERR/DECERR beats.
module ip4_rtl_rdbuf
    import ip4_rtl_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = RB_DATA_W,
    parameter int unsigned ID_W    = RB_ID_W,
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned MAX_OUT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    c_arvalid,
    output logic                    c_arready,
    input  logic [ADDR_W-1:0]       c_araddr,
    input  logic [ID_W-1:0]         c_arid,
    input  logic [7:0]              c_arlen,
    output logic                    f_arvalid,
    input  logic                    f_arready,
    output logic [ADDR_W-1:0]       f_araddr,
    output logic [ID_W-1:0]         f_arid,
    output logic [7:0]              f_arlen,
    input  logic                    f_rvalid,
    output logic                    f_rready,
    input  logic [DATA_W-1:0]       f_rdata,
    input  logic [ID_W-1:0]         f_rid,
    input  logic [1:0]              f_rresp,
    input  logic                    f_rlast,
    output logic                    c_rvalid,
    input  logic                    c_rready,
    output logic [DATA_W-1:0]       c_rdata,
    output logic [ID_W-1:0]         c_rid,
    output logic [1:0]              c_rresp,
    output logic                    c_rlast,
`ifdef IP4_RDBUF_ERR_EN
    output logic                    err_flag,
    output logic [15:0]             err_cnt,
`endif
    output logic [$clog2(DEPTH):0]  credits
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned OW = $clog2(MAX_OUT + 1);

    rdbuf_st_e     state;
    rdbuf_st_e     state_nxt;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] outstanding_nxt;
    logic [CW-1:0] credits_nxt;
    logic [8:0]    need_c;
    logic          fits_c;
    logic          reserve_c;
    logic          ar_hs_c;
    logic          r_hs_c;
    logic          rlast_hs_c;
    logic          fifo_empty;
    r_beat_s       wbeat;
    r_beat_s       rbeat;

    assign need_c     = 9'(f_arlen) + 9'd1;
    assign ar_hs_c    = f_arvalid && f_arready;
    assign r_hs_c     = c_rvalid && c_rready;
    assign rlast_hs_c = r_hs_c && c_rlast;

    // A release landing in the same cycle already counts toward the HOLD decision
    assign fits_c = ((32'(credits) + 32'(r_hs_c)) >= 32'(need_c)) &&
                    ((32'(outstanding) - 32'(rlast_hs_c)) < MAX_OUT);

    // AR FSM next state plus credit and outstanding bookkeeping
    always_comb begin
        state_nxt       = state;
        reserve_c       = 1'b0;
        outstanding_nxt = outstanding;
        case (state)
            IDLE:    if (c_arvalid) state_nxt = HOLD;
            HOLD:    if (fits_c) begin
                         reserve_c = 1'b1;
                         state_nxt = ISSUE;
                     end
            ISSUE:   if (f_arready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        credits_nxt = credits + CW'(r_hs_c) - (reserve_c ? CW'(need_c) : CW'(0));
        if (ar_hs_c && !rlast_hs_c) begin
            outstanding_nxt = outstanding + OW'(1);
        end else if (!ar_hs_c && rlast_hs_c) begin
            outstanding_nxt = outstanding - OW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            c_arready   <= 1'b1;
            f_arvalid   <= 1'b0;
            f_rready    <= 1'b1;
            f_araddr    <= '0;
            f_arid      <= '0;
            f_arlen     <= '0;
            credits     <= CW'(DEPTH);
            outstanding <= '0;
        end else begin
            state       <= state_nxt;
            c_arready   <= (state_nxt == IDLE);
            f_arvalid   <= (state_nxt == ISSUE);
            f_rready    <= 1'b1;
            credits     <= credits_nxt;
            outstanding <= outstanding_nxt;
            if (state == IDLE && c_arvalid) begin
                f_araddr <= c_araddr;
                f_arid   <= c_arid;
                f_arlen  <= c_arlen;
            end
        end
    end

    assign wbeat = '{data: RB_DATA_W'(f_rdata), id: RB_ID_W'(f_rid), resp: f_rresp, last: f_rlast};

    ip4_rtl_rdbuf_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (f_rvalid && f_rready),
        .wdata (wbeat),
        .rd    (r_hs_c),
        .rdata (rbeat),
        .empty (fifo_empty)
    );

    assign c_rvalid = !fifo_empty;
    assign c_rdata  = DATA_W'(rbeat.data);
    assign c_rid    = ID_W'(rbeat.id);
    assign c_rresp  = rbeat.resp;
    assign c_rlast  = rbeat.last;

`ifdef IP4_RDBUF_ERR_EN
    // Sticky error status; the counter saturates instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_flag <= 1'b0;
            err_cnt  <= '0;
        end else if (r_hs_c && c_rresp[1]) begin
            err_flag <= 1'b1;
            if (err_cnt != 16'hFFFF) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end
`endif

    a_burst_fits: assert property (@(posedge clk) disable iff (rst) !(state == HOLD && 32'(need_c) > DEPTH));

endmodule

// File: tb/tb_ip4_rtl_rdbuf.sv
// Randomized bench for ip4_rtl_rdbuf against a queue-based transaction model.
// Build with IP4_RDBUF_ERR_EN defined to also check err_flag / err_cnt.
module tb_ip4_rtl_rdbuf;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 128;
    localparam int unsigned ID_W    = 4;
    localparam int unsigned DEPTH   = 32;
    localparam int unsigned MAX_OUT = 8;
    localparam int unsigned CW      = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              c_arvalid, c_arready;
    logic [ADDR_W-1:0] c_araddr;
    logic [ID_W-1:0]   c_arid;
    logic [7:0]        c_arlen;
    logic              f_arvalid, f_arready;
    logic [ADDR_W-1:0] f_araddr;
    logic [ID_W-1:0]   f_arid;
    logic [7:0]        f_arlen;
    logic              f_rvalid, f_rready;
    logic [DATA_W-1:0] f_rdata;
    logic [ID_W-1:0]   f_rid;
    logic [1:0]        f_rresp;
    logic              f_rlast;
    logic              c_rvalid, c_rready;
    logic [DATA_W-1:0] c_rdata;
    logic [ID_W-1:0]   c_rid;
    logic [1:0]        c_rresp;
    logic              c_rlast;
    logic [CW-1:0]     credits;
`ifdef IP4_RDBUF_ERR_EN
    logic              err_flag;
    logic [15:0]       err_cnt;
`endif

    ip4_rtl_rdbuf #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk(clk), .rst(rst),
        .c_arvalid(c_arvalid), .c_arready(c_arready),
        .c_araddr(c_araddr), .c_arid(c_arid), .c_arlen(c_arlen),
        .f_arvalid(f_arvalid), .f_arready(f_arready),
        .f_araddr(f_araddr), .f_arid(f_arid), .f_arlen(f_arlen),
        .f_rvalid(f_rvalid), .f_rready(f_rready),
        .f_rdata(f_rdata), .f_rid(f_rid), .f_rresp(f_rresp), .f_rlast(f_rlast),
        .c_rvalid(c_rvalid), .c_rready(c_rready),
        .c_rdata(c_rdata), .c_rid(c_rid), .c_rresp(c_rresp), .c_rlast(c_rlast),
`ifdef IP4_RDBUF_ERR_EN
        .err_flag(err_flag), .err_cnt(err_cnt),
`endif
        .credits(credits)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [ID_W-1:0]   id;
        logic [7:0]        len;
    } ar_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ID_W-1:0]   id;
        logic [1:0]        resp;
        logic              last;
    } beat_t;

    // Model: requests queued at the core, accepted-but-unissued, fabric beats owed, beats buffered
    ar_t   stim_q[$];
    ar_t   req_q[$];
    beat_t fab_q[$];
    beat_t exp_q[$];

    int errors = 0;
    int checks = 0;
    int reserved, drained, out_m, err_m, seen_err, cyc, rises;
    int car_cyc, rlast_cyc;
    bit counted, lat_arm, lat_req, rise9_chk;
    bit p_car, p_far, p_fr, p_cr;
    int crr_mode, r_pct, arr_pct;
    bit r_en, force_en;
    logic [1:0] force_resp;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_all();
        c_arvalid = 1'b0; c_araddr = '0; c_arid = '0; c_arlen = '0;
        f_arready = 1'b0; f_rvalid = 1'b0; f_rdata = '0; f_rid = '0; f_rresp = '0; f_rlast = 1'b0;
        c_rready  = 1'b0;
        stim_q.delete(); req_q.delete(); fab_q.delete(); exp_q.delete();
        reserved = 0; drained = 0; out_m = 0; err_m = 0; seen_err = 0;
        counted = 1'b0; lat_req = 1'b0; p_car = 1'b0; p_far = 1'b0; p_fr = 1'b0; p_cr = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        clear_all();
        @(posedge clk); #1;
        chk({tag, "_c_arready"}, 256'(c_arready), 256'(1));
        chk({tag, "_f_arvalid"}, 256'(f_arvalid), 256'(0));
        chk({tag, "_c_rvalid"},  256'(c_rvalid),  256'(0));
        chk({tag, "_credits"},   256'(credits),   256'(DEPTH));
        chk({tag, "_f_rready"},  256'(f_rready),  256'(1));
        chk({tag, "_f_araddr"},  256'(f_araddr),  256'(0));
`ifdef IP4_RDBUF_ERR_EN
        chk({tag, "_err_cnt"},   256'(err_cnt),   256'(0));
`endif
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One clock: retire last cycle's handshakes into the model, check outputs, drive next inputs
    task automatic tick();
        ar_t   a;
        beat_t b;
        @(posedge clk); #1;
        cyc++;
        if (p_car) req_q.push_back(stim_q.pop_front());
        if (p_far) begin
            a = req_q.pop_front();
            counted = 1'b0;
            out_m++;
            for (int i = 0; i <= int'(a.len); i++) begin
                b.data = {$urandom, $urandom, $urandom, $urandom};
                b.id   = a.id;
                b.resp = force_en ? force_resp : 2'($urandom);
                b.last = (i == int'(a.len));
                fab_q.push_back(b);
            end
        end
        if (p_fr) exp_q.push_back(fab_q.pop_front());
        if (p_cr) begin
            b = exp_q.pop_front();
            drained++;
            if (b.last) out_m--;
            if (b.resp[1]) err_m++;
        end

        chk("f_rready", 256'(f_rready), 256'(1));
        chk("far_orphan", 256'(f_arvalid && req_q.size() == 0), 256'(0));
        if (f_arvalid && req_q.size() != 0) begin
            chk("far_payload", 256'({f_araddr, f_arid, f_arlen}), 256'(req_q[0]));
            if (!counted) begin
                counted = 1'b1;
                rises++;
                reserved += int'(req_q[0].len) + 1;
                chk("out_bound", 256'(out_m < int'(MAX_OUT)), 256'(1));
                if (lat_req) begin
                    chk("ar_latency", 256'(cyc - car_cyc), 256'(2));
                    lat_req = 1'b0;
                end
                if (rise9_chk && rises == 9) chk("ar9_after_rlast", 256'(cyc - rlast_cyc), 256'(1));
            end
        end
        chk("credits", 256'(credits), 256'(DEPTH - reserved + drained));
        chk("c_rvalid", 256'(c_rvalid), 256'(exp_q.size() != 0));
        if (c_rvalid && exp_q.size() != 0)
            chk("c_rbeat", 256'({c_rdata, c_rid, c_rresp, c_rlast}), 256'(exp_q[0]));
`ifdef IP4_RDBUF_ERR_EN
        chk("err_cnt", 256'(err_cnt), 256'(err_m));
        chk("err_flag", 256'(err_flag), 256'(err_m != 0));
`endif

        c_arvalid = (stim_q.size() != 0);
        if (c_arvalid) {c_araddr, c_arid, c_arlen} = stim_q[0];
        p_car = c_arvalid && c_arready;
        if (p_car && lat_arm) begin
            car_cyc = cyc;
            lat_arm = 1'b0;
            lat_req = 1'b1;
        end
        f_arready = ($urandom_range(99) < arr_pct);
        p_far = f_arvalid && f_arready;
        f_rvalid = r_en && fab_q.size() != 0 && ($urandom_range(99) < r_pct);
        if (f_rvalid) {f_rdata, f_rid, f_rresp, f_rlast} = fab_q[0];
        p_fr = f_rvalid && f_rready;
        c_rready = (crr_mode == 0) ? 1'b1 : (crr_mode == 1) ? 1'b0 : 1'($urandom_range(1));
        p_cr = c_rvalid && c_rready;
        if (p_cr) begin
            if (c_rresp[1]) seen_err++;
            if (c_rlast && rlast_cyc < 0) rlast_cyc = cyc;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        ar_t a;
        int  n;
        cyc = 0; rises = 0; rlast_cyc = -1; car_cyc = 0;
        lat_arm = 1'b0; rise9_chk = 1'b0; force_en = 1'b0; force_resp = 2'b00;
        crr_mode = 0; r_en = 1'b1; r_pct = 100; arr_pct = 100;
        do_reset("rst");

        // Single burst of 4 beats, AR latency and credit return
        lat_arm = 1'b1;
        stim_q.push_back('{addr: 32'h0000_1000, id: 4'h3, len: 8'd3});
        run(20);
        chk("t1_drained", 256'(drained), 256'(4));
        chk("t1_credits_back", 256'(credits), 256'(DEPTH));

        // Full-depth burst blocks a following single-beat burst until one beat drains
        crr_mode = 1;
        rises = 0;
        stim_q.push_back('{addr: 32'h0000_2000, id: 4'h5, len: 8'd31});
        stim_q.push_back('{addr: 32'h0000_3000, id: 4'h6, len: 8'd0});
        run(60);
        chk("t2_one_issued", 256'(rises), 256'(1));
        chk("t2_credits_zero", 256'(credits), 256'(0));
        crr_mode = 0;
        run(60);
        chk("t2_both_issued", 256'(rises), 256'(2));
        chk("t2_drained", 256'(c_rvalid), 256'(0));

        // Outstanding cap: eight issue while R is withheld, ninth follows the first rlast
        r_en = 1'b0;
        rises = 0;
        for (int i = 0; i < 9; i++) stim_q.push_back('{addr: 32'(i * 64), id: 4'(i), len: 8'd0});
        run(40);
        chk("t3_capped", 256'(rises), 256'(MAX_OUT));
        rise9_chk = 1'b1;
        rlast_cyc = -1;
        r_en = 1'b1;
        run(40);
        chk("t3_ninth", 256'(rises), 256'(9));
        rise9_chk = 1'b0;

        // Random traffic with back-pressure on every side, including full-depth bursts
        r_pct = 60; arr_pct = 70; crr_mode = 2;
        for (int i = 0; i < 60; i++) begin
            a.addr = $urandom;
            a.id   = 4'($urandom);
            a.len  = ($urandom_range(9) == 0) ? 8'd31 : 8'($urandom_range(7));
            stim_q.push_back(a);
        end
        n = 0;
        while ((stim_q.size() + req_q.size() + fab_q.size() + exp_q.size()) != 0 && n < 20000) begin
            tick();
            n++;
        end
        chk("t4_all_done", 256'(stim_q.size() + req_q.size() + fab_q.size() + exp_q.size()), 256'(0));
        chk("t4_credits", 256'(credits), 256'(DEPTH));

        // Reset in the middle of a burst
        r_pct = 100; arr_pct = 100; crr_mode = 1;
        stim_q.push_back('{addr: 32'h0000_4000, id: 4'h9, len: 8'd3});
        n = 0;
        while (exp_q.size() < 2 && n < 50) begin
            tick();
            n++;
        end
        chk("t5_mid_burst", 256'(c_rvalid), 256'(1));
        do_reset("t5");
        crr_mode = 0;

        // Error responses on every beat of a 3-beat burst
        force_en = 1'b1; force_resp = 2'b10;
        stim_q.push_back('{addr: 32'h0000_5000, id: 4'hA, len: 8'd2});
        run(20);
        force_en = 1'b0;
        chk("t6_resp_seen", 256'(seen_err), 256'(3));
`ifdef IP4_RDBUF_ERR_EN
        chk("t6_err_cnt", 256'(err_cnt), 256'(3));
        chk("t6_err_flag", 256'(err_flag), 256'(1));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
